// File: rtl/alarm_controller.sv
// Alarm-system control stage: input conditioning, arming FSM with exit/entry delays, siren and status code.
// Optional feature macro: ALARM_SIREN_TIMEOUT_EN (siren times out back to ARMED after SIREN_SECONDS).
module alarm_controller #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int TICK_CYCLES     = 100_000_000,
  parameter int EXIT_SECONDS    = 10,
  parameter int ENTRY_SECONDS   = 15,
  parameter int SIREN_SECONDS   = 60
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_door_raw,
  input  logic       i_btn_raw,
  output logic [2:0] o_status,
  output logic       o_siren,
  output logic       o_armed,
  output logic [7:0] o_seconds_left
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  if (EXIT_SECONDS < 1 || EXIT_SECONDS > 255 || ENTRY_SECONDS < 1 || ENTRY_SECONDS > 255 ||
      SIREN_SECONDS < 1 || SIREN_SECONDS > 255) begin : g_param_check
    $error("alarm_controller: delay parameters must lie in 1..255");
  end

  typedef enum logic [2:0] {
    S_DISARMED,
    S_EXIT_DELAY,
    S_ARMED,
    S_ENTRY_DELAY,
    S_ALARM
  } state_e;

  // Bit 0 carries the door, bit 1 the button through the shared conditioning path.
  logic [1:0]    sync1_q, sync1_d;
  logic [1:0]    sync2_q, sync2_d;
  logic [1:0]    deb_q, deb_d;
  logic [DW-1:0] db_cnt_q [2];
  logic [DW-1:0] db_cnt_d [2];
  logic          btn_prev_q, btn_prev_d;

  state_e        state_q, state_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [7:0]    sec_q, sec_d;
  logic [2:0]    status_q, status_d;
  logic          siren_q, siren_d;
  logic          armed_q, armed_d;

  logic btn_pulse;
  logic door_open;
  logic tick;
  logic expire;
  logic entering;

  assign btn_pulse = deb_q[1] & ~btn_prev_q;
  assign door_open = deb_q[0];
  assign tick      = (tick_cnt_q == TW'(TICK_CYCLES - 1));
  assign expire    = tick && (sec_q == 8'd1);
  assign entering  = (state_d != state_q);

  always_comb begin
    sync1_d    = {i_btn_raw, i_door_raw};
    sync2_d    = sync1_q;
    btn_prev_d = deb_q[1];
    deb_d      = deb_q;
    for (int i = 0; i < 2; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (db_cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          deb_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // A button pulse outranks every door event and delay expiry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_DISARMED: begin
        if (btn_pulse) state_d = S_EXIT_DELAY;
      end
      S_EXIT_DELAY: begin
        if (btn_pulse)   state_d = S_DISARMED;
        else if (expire) state_d = door_open ? S_ENTRY_DELAY : S_ARMED;
      end
      S_ARMED: begin
        if (btn_pulse)      state_d = S_DISARMED;
        else if (door_open) state_d = S_ENTRY_DELAY;
      end
      S_ENTRY_DELAY: begin
        if (btn_pulse)   state_d = S_DISARMED;
        else if (expire) state_d = S_ALARM;
      end
      S_ALARM: begin
        if (btn_pulse) state_d = S_DISARMED;
`ifdef ALARM_SIREN_TIMEOUT_EN
        else if (expire) state_d = S_ARMED;
`endif
      end
      default: state_d = S_DISARMED;
    endcase
  end

  always_comb begin
    sec_d      = 8'd0;
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    case (state_d)
      S_EXIT_DELAY: begin
        if (entering)  sec_d = 8'(EXIT_SECONDS);
        else if (tick) sec_d = sec_q - 8'd1;
        else           sec_d = sec_q;
      end
      S_ENTRY_DELAY: begin
        if (entering)  sec_d = 8'(ENTRY_SECONDS);
        else if (tick) sec_d = sec_q - 8'd1;
        else           sec_d = sec_q;
      end
`ifdef ALARM_SIREN_TIMEOUT_EN
      S_ALARM: begin
        if (entering)  sec_d = 8'(SIREN_SECONDS);
        else if (tick) sec_d = sec_q - 8'd1;
        else           sec_d = sec_q;
      end
`else
      S_ALARM: sec_d = 8'd0;
`endif
      default: sec_d = 8'd0;
    endcase
    // Every timed phase starts on a fresh prescaler so it lasts exactly N whole ticks.
    if (entering) tick_cnt_d = '0;
  end

  // Outputs are computed from the next state so they register alongside it.
  always_comb begin
    status_d = 3'b000;
    case (state_d)
      S_DISARMED:    status_d = door_open ? 3'b001 : 3'b000;
      S_EXIT_DELAY:  status_d = 3'b100;
      S_ARMED:       status_d = 3'b010;
      S_ENTRY_DELAY: status_d = 3'b001;
      S_ALARM:       status_d = 3'b011;
      default:       status_d = 3'b000;
    endcase
    siren_d = (state_d == S_ALARM);
    armed_d = (state_d != S_DISARMED);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      deb_q       <= '0;
      db_cnt_q[0] <= '0;
      db_cnt_q[1] <= '0;
      btn_prev_q  <= 1'b0;
      state_q     <= S_DISARMED;
      tick_cnt_q  <= '0;
      sec_q       <= 8'd0;
      status_q    <= 3'b000;
      siren_q     <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      deb_q       <= deb_d;
      db_cnt_q[0] <= db_cnt_d[0];
      db_cnt_q[1] <= db_cnt_d[1];
      btn_prev_q  <= btn_prev_d;
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      sec_q       <= sec_d;
      status_q    <= status_d;
      siren_q     <= siren_d;
      armed_q     <= armed_d;
    end
  end

  assign o_status       = status_q;
  assign o_siren        = siren_q;
  assign o_armed        = armed_q;
  assign o_seconds_left = sec_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Directed testbench for alarm_controller: hand-written latency/glitch/reset sequences plus a table of
// timed stimulus steps with hand-computed expected outputs. Honours ALARM_SIREN_TIMEOUT_EN.
module tb_alarm_controller;

  localparam int DEB     = 4;
  localparam int TICK    = 10;
  localparam int EXIT_S  = 3;
  localparam int ENTRY_S = 2;
  localparam int SIREN_S = 2;

`ifdef ALARM_SIREN_TIMEOUT_EN
  localparam bit TIMEOUT = 1'b1;
`else
  localparam bit TIMEOUT = 1'b0;
`endif

  // Alarm-phase expectations that differ between the two builds
  localparam logic [7:0] ALARM_SECS      = TIMEOUT ? 8'(SIREN_S) : 8'd0;
  localparam logic [7:0] ALARM_SECS_HALF = TIMEOUT ? 8'd1 : 8'd0;
  localparam logic [2:0] LATE_STATUS     = TIMEOUT ? 3'b010 : 3'b011;
  localparam logic       LATE_SIREN      = TIMEOUT ? 1'b0 : 1'b1;

  logic       clk;
  logic       rst_n;
  logic       door_raw;
  logic       btn_raw;
  logic [2:0] status;
  logic       siren;
  logic       armed;
  logic [7:0] secs;

  int compared;
  int mismatched;

  typedef struct {
    logic       door;
    logic       btn;
    int         cycles;
    logic [2:0] status;
    logic       siren;
    logic       armed;
    logic [7:0] secs;
  } vec_t;

  vec_t vecs[$];

  alarm_controller #(
    .DEBOUNCE_CYCLES(DEB),
    .TICK_CYCLES    (TICK),
    .EXIT_SECONDS   (EXIT_S),
    .ENTRY_SECONDS  (ENTRY_S),
    .SIREN_SECONDS  (SIREN_S)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_door_raw    (door_raw),
    .i_btn_raw     (btn_raw),
    .o_status      (status),
    .o_siren       (siren),
    .o_armed       (armed),
    .o_seconds_left(secs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic door, input logic btn, input int cycles);
    door_raw = door;
    btn_raw  = btn;
    step(cycles);
  endtask

  task automatic checkOutput(input string name, input logic [2:0] exp_status, input logic exp_siren,
                             input logic exp_armed, input logic [7:0] exp_secs);
    compared++;
    if (status !== exp_status || siren !== exp_siren || armed !== exp_armed || secs !== exp_secs) begin
      mismatched++;
      $display("[TB] FAIL %s: got status=%b siren=%b armed=%b secs=%0d, expected status=%b siren=%b armed=%b secs=%0d",
               name, status, siren, armed, secs, exp_status, exp_siren, exp_armed, exp_secs);
    end
  endtask

  task automatic addVec(input logic door, input logic btn, input int cycles, input logic [2:0] st,
                        input logic sr, input logic ar, input logic [7:0] sc);
    vec_t v;
    v.door   = door;
    v.btn    = btn;
    v.cycles = cycles;
    v.status = st;
    v.siren  = sr;
    v.armed  = ar;
    v.secs   = sc;
    vecs.push_back(v);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;

    // Arm with door closed, count down 3,2,1 then ARMED after exactly 30 cycles
    addVec(0, 1,  6, 3'b000, 0, 0, 8'd0);
    addVec(0, 1,  1, 3'b100, 0, 1, 8'd3);
    addVec(0, 0,  9, 3'b100, 0, 1, 8'd3);
    addVec(0, 0,  1, 3'b100, 0, 1, 8'd2);
    addVec(0, 0, 10, 3'b100, 0, 1, 8'd1);
    addVec(0, 0,  9, 3'b100, 0, 1, 8'd1);
    addVec(0, 0,  1, 3'b010, 0, 1, 8'd0);
    // Door opens while ARMED: entry delay of 2 s, then ALARM after 20 cycles
    addVec(1, 0,  6, 3'b010, 0, 1, 8'd0);
    addVec(1, 0,  1, 3'b001, 0, 1, 8'd2);
    addVec(1, 0, 19, 3'b001, 0, 1, 8'd1);
    addVec(1, 0,  1, 3'b011, 1, 1, ALARM_SECS);
    // Door closes in ALARM: alarm holds (or times out to ARMED in the timeout build)
    addVec(0, 0, 15, 3'b011, 1, 1, ALARM_SECS_HALF);
    addVec(0, 0,  5, LATE_STATUS, LATE_SIREN, 1, 8'd0);
    // Button disarms
    addVec(0, 1,  6, LATE_STATUS, LATE_SIREN, 1, 8'd0);
    addVec(0, 1,  1, 3'b000, 0, 0, 8'd0);
    addVec(0, 0, 10, 3'b000, 0, 0, 8'd0);
    // Cancel during exit delay at count 2
    addVec(0, 1,  6, 3'b000, 0, 0, 8'd0);
    addVec(0, 1,  1, 3'b100, 0, 1, 8'd3);
    addVec(0, 0, 10, 3'b100, 0, 1, 8'd2);
    addVec(0, 1,  6, 3'b100, 0, 1, 8'd2);
    addVec(0, 1,  1, 3'b000, 0, 0, 8'd0);
    addVec(0, 0, 10, 3'b000, 0, 0, 8'd0);
    // Re-arm, then button and door arrive together while ARMED: button wins
    addVec(0, 1,  7, 3'b100, 0, 1, 8'd3);
    addVec(0, 0, 30, 3'b010, 0, 1, 8'd0);
    addVec(1, 1,  6, 3'b010, 0, 1, 8'd0);
    addVec(1, 1,  1, 3'b001, 0, 0, 8'd0);
    addVec(1, 0, 10, 3'b001, 0, 0, 8'd0);
    // Arm with door open: door ignored during exit, expiry goes straight to ENTRY_DELAY, then ALARM
    addVec(1, 1,  7, 3'b100, 0, 1, 8'd3);
    addVec(1, 0, 29, 3'b100, 0, 1, 8'd1);
    addVec(1, 0,  1, 3'b001, 0, 1, 8'd2);
    addVec(1, 0, 20, 3'b011, 1, 1, ALARM_SECS);

    rst_n    = 1'b0;
    door_raw = 1'b0;
    btn_raw  = 1'b0;
    #1;
    checkOutput("reset_values", 3'b000, 0, 0, 8'd0);
    step(3);
    rst_n = 1'b1;
    step(2);
    checkOutput("after_reset_release", 3'b000, 0, 0, 8'd0);

    // Door open latency: status changes exactly 7 cycles after the raw edge
    applyStimulus(1, 0, 6);
    checkOutput("door_open_cycle6", 3'b000, 0, 0, 8'd0);
    step(1);
    checkOutput("door_open_cycle7", 3'b001, 0, 0, 8'd0);
    step(993);
    checkOutput("door_open_held", 3'b001, 0, 0, 8'd0);
    applyStimulus(0, 0, 6);
    checkOutput("door_close_cycle6", 3'b001, 0, 0, 8'd0);
    step(1);
    checkOutput("door_close_cycle7", 3'b000, 0, 0, 8'd0);

    // A 3-cycle glitch must never reach the outputs
    applyStimulus(1, 0, 3);
    door_raw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      checkOutput($sformatf("door_glitch_c%0d", i), 3'b000, 0, 0, 8'd0);
      step(1);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].door, vecs[i].btn, vecs[i].cycles);
      checkOutput($sformatf("vec%0d", i), vecs[i].status, vecs[i].siren, vecs[i].armed, vecs[i].secs);
    end

    // Asynchronous reset in ALARM: outputs clear with no clock edge
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_in_alarm", 3'b000, 0, 0, 8'd0);
    door_raw = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(8);
    checkOutput("post_reset_idle", 3'b000, 0, 0, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alarm_controller.md
# alarm_controller

Alarm-system control stage that sits directly upstream of the 7-segment display driver and produces the 3-bit status code that driver decodes. It synchronises and debounces the raw door sensor and the arm/disarm push-button, then runs the arming state machine with exit and entry delays timed by an internal seconds prescaler. It also drives the siren output and an exposed countdown value.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable cycles before a debounced input changes (10 ms at 100 MHz).
- TICK_CYCLES, 100_000_000: clock cycles per one-second tick.
- EXIT_SECONDS, 10: exit delay length, range 1..255.
- ENTRY_SECONDS, 15: entry delay length, range 1..255.
- SIREN_SECONDS, 60: siren duration; used only when ALARM_SIREN_TIMEOUT_EN is defined.

Ports:
- i_clk  input  1  system clock; single clock domain.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_door_raw  input  1  raw door switch, asynchronous; 1 = open.
- i_btn_raw  input  1  raw arm/disarm button, asynchronous; 1 = pressed.
- o_status  output  3  status code to the display driver.
- o_siren  output  1  siren enable.
- o_armed  output  1  high in EXIT_DELAY, ARMED, ENTRY_DELAY and ALARM.
- o_seconds_left  output  8  remaining seconds of the active delay; 0 outside delay states.

## Operation
- Input conditioning: each raw input passes through a 2-flop synchroniser, then a per-input stability counter. The debounced level takes the synchronised value once it has been stable for DEBOUNCE_CYCLES consecutive cycles. Any change restarts the counter.
- Button event: a one-cycle pulse on the rising edge of the debounced button. A held button generates no further pulses.
- State machine states and transitions:
  - DISARMED: a button pulse moves to EXIT_DELAY.
  - EXIT_DELAY: a button pulse moves to DISARMED (cancel). On expiry, the block moves to ENTRY_DELAY if the door is open, otherwise to ARMED. The door opening during this state is ignored.
  - ARMED: a button pulse moves to DISARMED. Otherwise, a debounced door-open moves to ENTRY_DELAY.
  - ENTRY_DELAY: a button pulse moves to DISARMED. On expiry, the block moves to ALARM.
  - ALARM: a button pulse moves to DISARMED. The door closing does not clear ALARM.
- Priority: a button pulse beats both door events and delay expiry in the same cycle.
- Countdown: on entry to EXIT_DELAY or ENTRY_DELAY, the tick prescaler clears to 0 and o_seconds_left loads EXIT_SECONDS or ENTRY_SECONDS. Each tick decrements the count. The tick that decrements 1 to 0 is the expiry event.
- o_status encoding: the display driver shows "OPEN" for 001, "OUT" for 100, and dashes for everything else.
  - 000: DISARMED with door closed.
  - 001: DISARMED with door open, or ENTRY_DELAY.
  - 100: EXIT_DELAY.
  - 010: ARMED.
  - 011: ALARM.
- o_siren is 1 only in ALARM.

## Timing
- All outputs are registered.
- Reset values: o_status=000, o_siren=0, o_armed=0, o_seconds_left=0. State=DISARMED, debounced levels=0, all counters=0.
- Raw edge to debounced level change: DEBOUNCE_CYCLES+2 cycles. Outputs reflect the resulting state one cycle later, for DEBOUNCE_CYCLES+3 cycles in total.
- Delay duration: from state entry to the next state is exactly N×TICK_CYCLES cycles, where N is EXIT_SECONDS or ENTRY_SECONDS.
- Tick counter width: ceil(log2(TICK_CYCLES)) bits; it wraps to 0 on reaching TICK_CYCLES-1.
- Reset mid-operation: asserting i_rst_n low forces all reset values immediately. No pending button pulse survives reset.

## Configuration
- ALARM_SIREN_TIMEOUT_EN defined: on entry to ALARM, a counter loads SIREN_SECONDS and counts down on ticks.
  - At expiry, o_siren drops and the state returns to ARMED. Door still open at that point re-enters ENTRY_DELAY on the next cycle.
  - o_seconds_left shows the siren countdown while in ALARM.
- ALARM_SIREN_TIMEOUT_EN undefined: ALARM persists until a button pulse or reset; o_seconds_left=0 in ALARM.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, TICK_CYCLES=10, EXIT_SECONDS=3, ENTRY_SECONDS=2, SIREN_SECONDS=2.
- Reset, then open the door for 1000 cycles -> o_status=001 exactly 7 cycles after the raw edge; a 3-cycle glitch on i_door_raw -> no change.
- Press the button with the door closed -> o_status=100, o_armed=1, o_seconds_left=3,2,1; after exactly 30 cycles, o_status=010.
- ARMED, open the door -> o_status=001 with a 2-second countdown; after 20 cycles, o_status=011 and o_siren=1. A button press -> 000, o_siren=0.
- EXIT_DELAY, press the button at count 2 -> DISARMED, o_status=000, o_armed=0. A button press on the same cycle the debounced door opens in ARMED -> DISARMED.
- Pull i_rst_n low in ALARM -> all outputs reset immediately, asynchronously, with no clock edge.
- With ALARM_SIREN_TIMEOUT_EN defined: in ALARM with the door closed, after 20 cycles -> o_siren=0 and o_status=010.
